// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   state_t : arbiter FSM states
//   grant_t : which requester owns the RAM port (GNT_I fetch, GNT_D data)
//   size_t  : data access size (HALF / WORD)
//   MEM_BYTES_DEFAULT : default RAM size in bytes
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_CAP,
    WR,
    RMW_RD,
    RMW_CAP,
    DONE
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  typedef enum logic {
    HALF = 1'b0,
    WORD = 1'b1
  } size_t;

  localparam int unsigned MEM_BYTES_DEFAULT = 65536;

endpackage

// File: rtl/load_formatter.sv
// Formats a raw RAM word for the data port.
//   raw       in  32  word as read from RAM
//   size      in  1   WORD passes through; HALF uses raw[15:0]
//   is_signed in  1   halfword sign extension when 1, zero extension when 0
//   data      out 32  formatted load data
module load_formatter
  import mem_arb_pkg::*;
(
  input  logic [31:0] raw,
  input  size_t       size,
  input  logic        is_signed,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    if (size == HALF) begin
      data = is_signed ? {{16{raw[15]}}, raw[15:0]} : {16'h0000, raw[15:0]};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit byte-addressed RAM port between the instruction-fetch
// port (I) and the load/store data port (D). Halfword stores are done as
// read-modify-write; halfword load extension is done here, the RAM is
// always asked for full unsigned words.
//   clk, reset                    clock, async active-high reset
//   i_req/i_addr                  fetch request (word read)
//   i_ready/i_rdata/i_err         fetch completion pulse, raw word, address error
//   d_req/d_we/d_word/d_sign      data request, write, word(1)/half(0), signed load
//   d_addr/d_wdata                data address, store data
//   d_ready/d_rdata/d_err         data completion pulse, formatted data, address error
//   ram_read/ram_write            registered RAM strobes (never both high)
//   ram_word/ram_sign             constant 1 / 0
//   ram_address/ram_dataIn        registered RAM address and write data
//   ram_dataOut                   RAM read data, valid the cycle after ram_read
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE  = 1,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_word,
  input  logic        d_sign,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ram_read,
  output logic        ram_write,
  output logic        ram_word,
  output logic        ram_sign,
  output logic [31:0] ram_address,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut
);

  state_t      state, state_n;
  grant_t      gnt, gnt_n, last_grant, last_grant_n;
  logic [31:0] addr_q, addr_n;
  size_t       size_q, size_n;
  logic        sign_q, sign_n;
  logic [31:0] wdata_q, wdata_n;

  logic        ram_read_n, ram_write_n;
  logic [31:0] ram_address_n, ram_data_in_n;
  logic        i_ready_n, i_err_n, d_ready_n, d_err_n;
  logic [31:0] i_rdata_n, d_rdata_n;

  // Candidate grant and its request fields, valid whenever someone is eligible.
  logic        i_elig, d_elig;
  grant_t      pick;
  logic [31:0] req_addr, req_wdata;
  logic        req_we, req_sign;
  size_t       req_size;
  logic [31:0] fmt_data;

  assign ram_word = 1'b1;
  assign ram_sign = 1'b0;

  load_formatter u_fmt (
    .raw       (ram_dataOut),
    .size      (size_q),
    .is_signed (sign_q),
    .data      (fmt_data)
  );

  // A port whose completion pulse is showing is not eligible, so a request
  // still held during its ready cycle cannot be accepted twice.
  assign i_elig = i_req & ~i_ready;
  assign d_elig = d_req & ~d_ready;

  always_comb begin
    if (i_elig && d_elig) begin
      if (ARB_MODE != 0) pick = (last_grant == GNT_I) ? GNT_D : GNT_I;
      else               pick = GNT_D;
    end else begin
      pick = d_elig ? GNT_D : GNT_I;
    end
    if (pick == GNT_D) begin
      req_addr  = d_addr;
      req_we    = d_we;
      req_size  = size_t'(d_word);
      req_sign  = d_sign;
      req_wdata = d_wdata;
    end else begin
      req_addr  = i_addr;
      req_we    = 1'b0;
      req_size  = WORD;
      req_sign  = 1'b0;
      req_wdata = '0;
    end
  end

  always_comb begin
    state_n       = state;
    gnt_n         = gnt;
    last_grant_n  = last_grant;
    addr_n        = addr_q;
    size_n        = size_q;
    sign_n        = sign_q;
    wdata_n       = wdata_q;
    ram_read_n    = 1'b0;
    ram_write_n   = 1'b0;
    ram_data_in_n = '0;
    i_ready_n     = 1'b0;
    i_err_n       = 1'b0;
    i_rdata_n     = i_rdata;
    d_ready_n     = 1'b0;
    d_err_n       = 1'b0;
    d_rdata_n     = d_rdata;

    case (state)
      IDLE: begin
        if (i_elig || d_elig) begin
          gnt_n        = pick;
          last_grant_n = pick;
          addr_n       = req_addr;
          size_n       = req_size;
          sign_n       = req_sign;
          wdata_n      = req_wdata;
          if (req_addr > 32'(MEM_BYTES - 4)) begin
            state_n = DONE;
            if (pick == GNT_I) begin
              i_ready_n = 1'b1;
              i_err_n   = 1'b1;
              i_rdata_n = '0;
            end else begin
              d_ready_n = 1'b1;
              d_err_n   = 1'b1;
              d_rdata_n = '0;
            end
          end else if (!req_we) begin
            state_n    = RD;
            ram_read_n = 1'b1;
          end else if (req_size == WORD) begin
            state_n       = WR;
            ram_write_n   = 1'b1;
            ram_data_in_n = req_wdata;
          end else begin
            state_n    = RMW_RD;
            ram_read_n = 1'b1;
          end
        end
      end
      RD:     state_n = RD_CAP;
      RD_CAP: begin
        state_n = DONE;
        if (gnt == GNT_I) begin
          i_ready_n = 1'b1;
          i_rdata_n = ram_dataOut;
        end else begin
          d_ready_n = 1'b1;
          d_rdata_n = fmt_data;
        end
      end
      WR: begin
        state_n   = DONE;
        d_ready_n = 1'b1;
      end
      RMW_RD: state_n = RMW_CAP;
      RMW_CAP: begin
        // The merged word replaces the latched store data and becomes the
        // write buffer for the following WR cycle.
        wdata_n       = {ram_dataOut[31:16], wdata_q[15:0]};
        state_n       = WR;
        ram_write_n   = 1'b1;
        ram_data_in_n = {ram_dataOut[31:16], wdata_q[15:0]};
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Address is presented for the whole operation, cleared outside it.
    ram_address_n = (state_n == IDLE || state_n == DONE) ? '0 : addr_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gnt         <= GNT_I;
      last_grant  <= GNT_I;
      addr_q      <= '0;
      size_q      <= HALF;
      sign_q      <= 1'b0;
      wdata_q     <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_dataIn  <= '0;
      i_ready     <= 1'b0;
      i_err       <= 1'b0;
      i_rdata     <= '0;
      d_ready     <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= '0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      last_grant  <= last_grant_n;
      addr_q      <= addr_n;
      size_q      <= size_n;
      sign_q      <= sign_n;
      wdata_q     <= wdata_n;
      ram_read    <= ram_read_n;
      ram_write   <= ram_write_n;
      ram_address <= ram_address_n;
      ram_dataIn  <= ram_data_in_n;
      i_ready     <= i_ready_n;
      i_err       <= i_err_n;
      i_rdata     <= i_rdata_n;
      d_ready     <= d_ready_n;
      d_err       <= d_err_n;
      d_rdata     <= d_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance backed by a
// word RAM model, plus a fixed-priority instance used for the tie test.
module tb_mem_port_arbiter;

  logic        clk, reset;
  logic        i_req, d_req, i_req1, d_req1;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        d_we, d_word, d_sign;

  logic        i_ready, i_err, d_ready, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        ram_read, ram_write, ram_word, ram_sign;
  logic [31:0] ram_address, ram_data_in, ram_data_out;

  logic        i_ready1, i_err1, d_ready1, d_err1;
  logic [31:0] i_rdata1, d_rdata1;
  logic        ram_read1, ram_write1, ram_word1, ram_sign1;
  logic [31:0] ram_address1, ram_data_in1, ram_data_out1;

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  logic sign_seen = 1'b0;
  logic both_seen = 1'b0;

  logic [31:0] mem [0:16383];

  mem_port_arbiter #(.ARB_MODE(1), .MEM_BYTES(65536)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_word(d_word), .d_sign(d_sign),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .ram_read(ram_read), .ram_write(ram_write), .ram_word(ram_word), .ram_sign(ram_sign),
    .ram_address(ram_address), .ram_dataIn(ram_data_in), .ram_dataOut(ram_data_out)
  );

  mem_port_arbiter #(.ARB_MODE(0), .MEM_BYTES(65536)) dut_fixed (
    .clk(clk), .reset(reset),
    .i_req(i_req1), .i_addr(i_addr), .i_ready(i_ready1), .i_rdata(i_rdata1), .i_err(i_err1),
    .d_req(d_req1), .d_we(d_we), .d_word(d_word), .d_sign(d_sign),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready1), .d_rdata(d_rdata1), .d_err(d_err1),
    .ram_read(ram_read1), .ram_write(ram_write1), .ram_word(ram_word1), .ram_sign(ram_sign1),
    .ram_address(ram_address1), .ram_dataIn(ram_data_in1), .ram_dataOut(ram_data_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous word RAM: write and read sampled on posedge.
  always @(posedge clk) begin
    if (ram_write) mem[ram_address[15:2]] <= ram_data_in;
    if (ram_read)  ram_data_out <= mem[ram_address[15:2]];
  end

  always @(posedge clk) begin
    if (ram_read1) ram_data_out1 <= ram_address1 ^ 32'h5A5A_0000;
  end

  always @(negedge clk) begin
    if (ram_read)  rd_cnt++;
    if (ram_write) wr_cnt++;
    if (ram_sign || ram_sign1 || !ram_word || !ram_word1) sign_seen = 1'b1;
    if ((ram_read && ram_write) || (ram_read1 && ram_write1)) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic d_xfer(input logic we, input logic word, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int cycles, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    d_we = we; d_word = word; d_sign = sign; d_addr = addr; d_wdata = wdata;
    d_req = 1'b1;
    cycles = 0; rdata = '0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (d_ready) begin
        cycles = n; rdata = d_rdata; err = d_err;
        break;
      end
    end
    d_req = 1'b0;
    if (cycles == 0) check("d_timeout", 32'd0, 32'd1);
  endtask

  task automatic i_xfer(input logic [31:0] addr, output int cycles,
                        output logic [31:0] rdata, output logic err);
    @(negedge clk);
    i_addr = addr;
    i_req = 1'b1;
    cycles = 0; rdata = '0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (i_ready) begin
        cycles = n; rdata = i_rdata; err = i_err;
        break;
      end
    end
    i_req = 1'b0;
    if (cycles == 0) check("i_timeout", 32'd0, 32'd1);
  endtask

  // Holds both requests of one instance and checks which port completes each time.
  task automatic arb_run(input logic fixed_inst, input logic [3:0] exp_d);
    logic rdy_i, rdy_d;
    @(negedge clk);
    i_addr = 32'd0; d_addr = 32'd400; d_we = 1'b0; d_word = 1'b1; d_sign = 1'b0;
    if (fixed_inst) begin i_req1 = 1'b1; d_req1 = 1'b1; end
    else            begin i_req  = 1'b1; d_req  = 1'b1; end
    for (int k = 0; k < 4; k++) begin
      rdy_i = 1'b0; rdy_d = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        rdy_i = fixed_inst ? i_ready1 : i_ready;
        rdy_d = fixed_inst ? d_ready1 : d_ready;
        if (rdy_i || rdy_d) break;
      end
      check($sformatf("arb%0d_seen_%0d", fixed_inst, k), 32'(rdy_i || rdy_d), 32'd1);
      check($sformatf("arb%0d_grant_%0d", fixed_inst, k), {rdy_i, rdy_d}, {~exp_d[k], exp_d[k]});
    end
    i_req = 1'b0; d_req = 1'b0; i_req1 = 1'b0; d_req1 = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [31:0] rd;
    logic        er;
    int          rd0, wr0;
    logic        seen;

    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; i_req1 = 1'b0; d_req1 = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_word = 1'b1; d_sign = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {24'd0, ram_read, ram_write, d_ready, d_err, i_ready, i_err, ram_sign, ram_word},
          32'h0000_0001);
    check("rst_addr", ram_address, 32'd0);
    check("rst_rdata", d_rdata | i_rdata | ram_data_in, 32'd0);
    reset = 1'b0;

    // Word store then word load
    d_xfer(1'b1, 1'b1, 1'b0, 32'd400, 32'hF00F_F176, cyc, rd, er);
    d_xfer(1'b0, 1'b1, 1'b0, 32'd400, 32'h0, cyc, rd, er);
    check("t1_ld_data", rd, 32'hF00F_F176);
    check("t1_ld_latency", 32'(cyc), 32'd3);
    check("t1_ld_err", 32'(er), 32'd0);

    // Halfword loads
    d_xfer(1'b0, 1'b0, 1'b1, 32'd400, 32'h0, cyc, rd, er);
    check("t2_half_signed", rd, 32'hFFFF_F176);
    d_xfer(1'b0, 1'b0, 1'b0, 32'd400, 32'h0, cyc, rd, er);
    check("t2_half_unsigned", rd, 32'h0000_F176);

    // Halfword store via read-modify-write; upper store bits must be ignored
    rd0 = rd_cnt; wr0 = wr_cnt;
    d_xfer(1'b1, 1'b0, 1'b0, 32'd400, 32'hDEAD_1234, cyc, rd, er);
    check("t3_rmw_reads", 32'(rd_cnt - rd0), 32'd1);
    check("t3_rmw_writes", 32'(wr_cnt - wr0), 32'd1);
    d_xfer(1'b0, 1'b1, 1'b0, 32'd400, 32'h0, cyc, rd, er);
    check("t3_ld_after_rmw", rd, 32'hF00F_1234);

    // Arbitration from reset
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    arb_run(1'b0, 4'b0101);
    arb_run(1'b1, 4'b1111);

    // Address errors and the last valid word
    rd0 = rd_cnt;
    d_xfer(1'b0, 1'b1, 1'b0, 32'd65534, 32'h0, cyc, rd, er);
    check("t5_err_flag", 32'(er), 32'd1);
    check("t5_err_rdata", rd, 32'd0);
    check("t5_err_no_read", 32'(rd_cnt - rd0), 32'd0);
    d_xfer(1'b1, 1'b1, 1'b0, 32'd65532, 32'h1357_2468, cyc, rd, er);
    i_xfer(32'd65532, cyc, rd, er);
    check("t5_fetch_data", rd, 32'h1357_2468);
    check("t5_fetch_err", 32'(er), 32'd0);
    check("t5_fetch_latency", 32'(cyc), 32'd3);

    // Reset during RMW_CAP of a halfword store
    @(negedge clk);
    d_we = 1'b1; d_word = 1'b0; d_sign = 1'b0; d_addr = 32'd400; d_wdata = 32'h0000_AAAA;
    d_req = 1'b1;
    wr0 = wr_cnt;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t6_pre_addr", ram_address, 32'd400);
    reset = 1'b1;
    #1;
    check("t6_async_ctrl", {24'd0, ram_read, ram_write, d_ready, d_err, i_ready, i_err, ram_sign, ram_word},
          32'h0000_0001);
    check("t6_async_addr", ram_address, 32'd0);
    check("t6_async_irdata", i_rdata, 32'd0);
    d_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (d_ready) seen = 1'b1;
    end
    check("t6_no_ready", 32'(seen), 32'd0);
    check("t6_no_write", 32'(wr_cnt - wr0), 32'd0);
    d_xfer(1'b0, 1'b1, 1'b0, 32'd400, 32'h0, cyc, rd, er);
    check("t6_ld_after_rst", rd, 32'hF00F_1234);

    check("ram_sign_word_const", 32'(sign_seen), 32'd0);
    check("rd_wr_exclusive", 32'(both_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
